// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared types and constants for the seven-segment scan driver:
//   controller state encoding, 4-bit to a..g segment decode and the
//   overflow dash pattern. Segment vectors are bit0 = a ... bit6 = g.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } seg7_state_t;

    localparam logic [6:0] SEG_DASH = 7'h40;

    function automatic logic [6:0] seg_decode(input logic [3:0] i_val);
        logic [6:0] v_seg;
        case (i_val)
            4'h0:    v_seg = 7'h3F;
            4'h1:    v_seg = 7'h06;
            4'h2:    v_seg = 7'h5B;
            4'h3:    v_seg = 7'h4F;
            4'h4:    v_seg = 7'h66;
            4'h5:    v_seg = 7'h6D;
            4'h6:    v_seg = 7'h7D;
            4'h7:    v_seg = 7'h07;
            4'h8:    v_seg = 7'h7F;
            4'h9:    v_seg = 7'h6F;
            4'hA:    v_seg = 7'h77;
            4'hB:    v_seg = 7'h7C;
            4'hC:    v_seg = 7'h39;
            4'hD:    v_seg = 7'h5E;
            4'hE:    v_seg = 7'h79;
            default: v_seg = 7'h71;
        endcase
        return v_seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential shift-add-3 (double dabble) binary to BCD converter.
//   One bit per cycle, BIN_W cycles after the start edge; done pulses for
//   one cycle together with the final result.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       begin a conversion of bin (ignored while busy)
//   bin         binary value
//   busy        conversion in progress
//   done        one-cycle pulse, bcd valid
//   bcd         N_DIGITS+1 BCD digits; the top digit flags overflow
module bin2bcd_seq #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*N_DIGITS+3:0]   bcd
);

    localparam int          BCD_W = 4 * N_DIGITS + 4;
    localparam int unsigned N_BCD = N_DIGITS + 1;
    localparam int          CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    logic [BIN_W-1:0] r_shift;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;
    logic             r_done;
    logic             r_lost;
    logic [BCD_W-1:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int unsigned d = 0; d < N_BCD; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && !r_active) begin
                r_shift  <= bin;
                r_bcd    <= '0;
                r_cnt    <= '0;
                r_active <= 1'b1;
                r_lost   <= 1'b0;
            end else if (r_active) begin
                {r_bcd, r_shift} <= {w_adj, r_shift} << 1;
                // a set bit leaving the top digit means the value no longer
                // fits in N_DIGITS+1 digits; remember it so overflow stays visible
                r_lost <= r_lost | w_adj[BCD_W-1];
                r_cnt  <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(BIN_W - 1)) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign busy = r_active;
    assign done = r_done;
    assign bcd  = r_lost ? {4'hF, r_bcd[BCD_W-5:0]} : r_bcd;

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed seven-segment display driver. A load captures bin_in either
//   as hex digits (immediate) or as decimal (via bin2bcd_seq); the display
//   register is then scanned one digit per SCAN_DIV clocks.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   ena         enable scanning and loads
//   load        capture strobe for bin_in / hex_mode
//   bin_in      value to display
//   hex_mode    1 = hex, 0 = decimal (sampled with load)
//   blank_lz    blank leading zero digits (live)
//   seg         segments a..g (bit0 = a)
//   dig_en      one-hot digit select
//   busy        decimal conversion in progress
//   ovf         last decimal load did not fit in N_DIGITS digits
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int BIN_W          = 14,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                load,
    input  logic [BIN_W-1:0]    bin_in,
    input  logic                hex_mode,
    input  logic                blank_lz,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] dig_en,
    output logic                busy,
    output logic                ovf
);

    localparam int DISP_W  = 4 * N_DIGITS;
    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    seg7_state_t         r_state;
    seg7_state_t         w_state_nxt;
    logic                w_start;
    logic                w_hex_ld;
    logic                w_done_ld;

    logic [DISP_W-1:0]   r_disp;
    logic                r_dash;
    logic                r_ovf;
    logic                r_busy;
    logic [PRESC_W-1:0]  r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [6:0]          r_seg;
    logic [N_DIGITS-1:0] r_dig_en;

    logic                w_conv_busy;
    logic                w_conv_done;
    logic [DISP_W+3:0]   w_bcd;
    logic                w_bcd_ovf;
    logic [DISP_W-1:0]   w_hex_val;
    logic [3:0]          w_digit;
    logic [N_DIGITS-1:0] w_lz;
    logic [6:0]          w_seg_nxt;

    bin2bcd_seq #(
        .N_DIGITS (N_DIGITS),
        .BIN_W    (BIN_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .bin   (bin_in),
        .busy  (w_conv_busy),
        .done  (w_conv_done),
        .bcd   (w_bcd)
    );

    assign w_bcd_ovf = |w_bcd[DISP_W+3:DISP_W];

    if (BIN_W >= DISP_W) begin : g_hex_trunc
        assign w_hex_val = bin_in[DISP_W-1:0];
    end else begin : g_hex_ext
        assign w_hex_val = {{(DISP_W - BIN_W){1'b0}}, bin_in};
    end

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_hex_ld    = 1'b0;
        w_done_ld   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load && ena) begin
                    if (hex_mode) begin
                        w_hex_ld = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_CONV;
                    end
                end
            end
            ST_CONV: begin
                if (w_conv_done && !w_conv_busy) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done_ld   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- display register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_disp <= '0;
            r_dash <= 1'b0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_hex_ld) begin
                r_disp <= w_hex_val;
                r_dash <= 1'b0;
            end
            if (w_done_ld) begin
                if (w_bcd_ovf) begin
                    r_dash <= 1'b1;
                    r_ovf  <= 1'b1;
                end else begin
                    r_disp <= w_bcd[DISP_W-1:0];
                    r_dash <= 1'b0;
                    r_ovf  <= 1'b0;
                end
            end
        end
    end

    // ---------------- scan ----------------
    // A digit is blanked when it and every more significant digit are zero.
    always_comb begin
        logic v_seen;
        v_seen = 1'b0;
        w_lz   = '0;
        for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
            if (r_disp[4*i +: 4] != 4'd0) begin
                v_seen = 1'b1;
            end
            w_lz[i] = !v_seen;
        end
    end

    assign w_digit = r_disp[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_seg_nxt = seg_decode(w_digit);
        if (!ena) begin
            w_seg_nxt = 7'h00;
        end else if (r_dash) begin
            w_seg_nxt = SEG_DASH;
        end else if (blank_lz && w_lz[r_idx]) begin
            w_seg_nxt = 7'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_idx    <= '0;
            r_seg    <= '0;
            r_dig_en <= '0;
        end else begin
            r_seg    <= w_seg_nxt;
            r_dig_en <= ena ? (N_DIGITS'(1) << r_idx) : '0;
            if (ena) begin
                if (r_presc == PRESC_W'(SCAN_DIV - 1)) begin
                    r_presc <= '0;
                    r_idx   <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
                end else begin
                    r_presc <= r_presc + PRESC_W'(1);
                end
            end
        end
    end

    assign seg    = (SEG_ACTIVE_LOW != 0) ? ~r_seg : r_seg;
    assign dig_en = (SEG_ACTIVE_LOW != 0) ? ~r_dig_en : r_dig_en;
    assign busy   = r_busy;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver (4 digits, 14-bit input, 4-clock
//   scan slot). Expected digit images are queued by the stimulus; a monitor
//   pops each entry when the DUT scans the matching dig_en and compares.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        load;
    logic [13:0] bin_in;
    logic        hex_mode;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        busy;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    string       q_name[$];
    logic [3:0]  q_dig[$];
    logic [6:0]  q_seg[$];
    logic        q_ovf[$];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS       (4),
        .BIN_W          (14),
        .SCAN_DIV       (4),
        .SEG_ACTIVE_LOW (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .load     (load),
        .bin_in   (bin_in),
        .hex_mode (hex_mode),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dig_en   (dig_en),
        .busy     (busy),
        .ovf      (ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_digit(input string nm, input logic [3:0] d,
                                input logic [6:0] s, input logic o);
        q_name.push_back(nm);
        q_dig.push_back(d);
        q_seg.push_back(s);
        q_ovf.push_back(o);
    endtask

    // segment images for digit3..digit0
    task automatic expect_all(input string nm, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0, input logic o);
        expect_digit({nm, " d0"}, 4'b0001, s0, o);
        expect_digit({nm, " d1"}, 4'b0010, s1, o);
        expect_digit({nm, " d2"}, 4'b0100, s2, o);
        expect_digit({nm, " d3"}, 4'b1000, s3, o);
    endtask

    // monitor: compares when the DUT scans the digit at the head of the queue
    int unsigned mon_wait = 0;
    always @(negedge clk) begin
        if (q_dig.size() != 0) begin
            if (dig_en === q_dig[0]) begin
                chk({q_name[0], " seg"}, 32'(seg), 32'(q_seg[0]));
                chk({q_name[0], " ovf"}, 32'(ovf), 32'(q_ovf[0]));
                void'(q_name.pop_front());
                void'(q_dig.pop_front());
                void'(q_seg.pop_front());
                void'(q_ovf.pop_front());
                mon_wait = 0;
            end else begin
                mon_wait++;
                if (mon_wait > 64) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s timeout: dig_en=%b never showed expected %b",
                             q_name[0], dig_en, q_dig[0]);
                    void'(q_name.pop_front());
                    void'(q_dig.pop_front());
                    void'(q_seg.pop_front());
                    void'(q_ovf.pop_front());
                    mon_wait = 0;
                end
            end
        end
    end

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (q_dig.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (q_dig.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s drain: %0d entries left, required 0", nm, q_dig.size());
        end
    endtask

    // called at posedge+1; the edge it waits for is the load edge
    task automatic do_load(input logic [13:0] v, input logic hx);
        bin_in   = v;
        hex_mode = hx;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // counts cycles with busy=1, bounded; returns at a negedge with busy=0
    task automatic wait_busy(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n    = 1'b0;
        ena      = 1'b1;
        load     = 1'b0;
        bin_in   = '0;
        hex_mode = 1'b0;
        blank_lz = 1'b0;

        // reset held for 3 edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst dig_en", 32'(dig_en), 32'h0);
        chk("rst seg", 32'(seg), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst ovf", 32'(ovf), 32'h0);
        next_edge();
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("first dig_en", 32'(dig_en), 32'h1);
        chk("first seg", 32'(seg), 32'h3F);
        chk("first busy", 32'(busy), 32'h0);
        chk("first ovf", 32'(ovf), 32'h0);
        next_edge();

        // decimal 1234
        do_load(14'd1234, 1'b0);
        wait_busy(cyc);
        chk("dec1234 busy cycles", 32'(cyc), 32'd16);
        next_edge();
        expect_all("dec1234", 7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0);
        drain("dec1234");
        next_edge();

        // hex 0x2A5C: immediate, no busy
        do_load(14'h2A5C, 1'b1);
        @(negedge clk);
        chk("hex busy", 32'(busy), 32'h0);
        next_edge();
        expect_all("hex2A5C", 7'h5B, 7'h77, 7'h6D, 7'h39, 1'b0);
        drain("hex2A5C");
        next_edge();

        // decimal 7 with leading-zero blanking, then blanking off
        blank_lz = 1'b1;
        do_load(14'd7, 1'b0);
        wait_busy(cyc);
        next_edge();
        expect_all("dec7 blank", 7'h00, 7'h00, 7'h00, 7'h07, 1'b0);
        drain("dec7 blank");
        next_edge();
        blank_lz = 1'b0;
        next_edge();
        expect_all("dec7 noblank", 7'h3F, 7'h3F, 7'h3F, 7'h07, 1'b0);
        drain("dec7 noblank");
        next_edge();

        // overflow, then recovery
        do_load(14'd12000, 1'b0);
        wait_busy(cyc);
        chk("ovf12000 flag", 32'(ovf), 32'h1);
        next_edge();
        expect_all("ovf12000", 7'h40, 7'h40, 7'h40, 7'h40, 1'b1);
        drain("ovf12000");
        next_edge();
        do_load(14'd9999, 1'b0);
        wait_busy(cyc);
        chk("dec9999 flag", 32'(ovf), 32'h0);
        next_edge();
        expect_all("dec9999", 7'h6F, 7'h6F, 7'h6F, 7'h6F, 1'b0);
        drain("dec9999");
        next_edge();

        // second load during conversion is dropped
        do_load(14'd55, 1'b0);
        next_edge();
        next_edge();
        do_load(14'd66, 1'b0);
        wait_busy(cyc);
        chk("load55 busy tail", 32'(cyc), 32'd13);
        repeat (20) @(negedge clk);
        chk("load66 ignored busy", 32'(busy), 32'h0);
        next_edge();
        expect_all("dec55", 7'h3F, 7'h3F, 7'h6D, 7'h6D, 1'b0);
        drain("dec55");
        next_edge();

        // reset in the middle of a conversion
        do_load(14'd4321, 1'b0);
        repeat (5) next_edge();
        rst_n = 1'b0;
        next_edge();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst busy", 32'(busy), 32'h0);
        next_edge();
        expect_all("midrst", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);
        drain("midrst");
        repeat (20) @(negedge clk);
        chk("midrst no resume", 32'(busy), 32'h0);
        next_edge();

        // ena=0 blanks the outputs; a running conversion still completes
        do_load(14'd42, 1'b0);
        ena = 1'b0;
        wait_busy(cyc);
        chk("ena0 conv busy cycles", 32'(cyc), 32'd16);
        chk("ena0 dig_en", 32'(dig_en), 32'h0);
        chk("ena0 seg", 32'(seg), 32'h0);
        next_edge();
        do_load(14'd99, 1'b0);
        @(negedge clk);
        chk("ena0 load ignored", 32'(busy), 32'h0);
        next_edge();
        ena = 1'b1;
        next_edge();
        expect_all("dec42", 7'h3F, 7'h3F, 7'h66, 7'h5B, 1'b0);
        drain("dec42");

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
